// File: rtl/line_window_3x3_if.sv
`default_nettype none
// ============================================================================
// Module      : line_window_3x3_if
// Description : Pixel-stream in / 3x3-window-stream out bundle for the
//               line_window_3x3 block. The master side is the pixel source
//               (and window consumer). The slave side is the window generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_window_3x3_if #(
    parameter int DATA_W = 8
) ();
    logic                  In_Valid;
    logic [DATA_W-1:0]     In_Pixel;
    logic                  Out_Valid;
    logic [9*DATA_W-1:0]   Out_Window;
    logic                  Out_Last;

    modport master (
        output In_Valid,
        output In_Pixel,
        input  Out_Valid,
        input  Out_Window,
        input  Out_Last
    );

    modport slave (
        input  In_Valid,
        input  In_Pixel,
        output Out_Valid,
        output Out_Window,
        output Out_Last
    );
endinterface
`default_nettype wire

// File: rtl/line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : line_window_3x3
// Description : Streaming 3x3 neighbourhood generator. Two internal line
//               buffers hold the previous two image lines. One registered
//               window is emitted per accepted pixel at (r>=2, c>=2).
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic               clk,
    input  logic               rst,
    line_window_3x3_if.slave   win_if
);
    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);
    localparam logic [c_col_w-1:0] c_col_max = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_max = c_row_w'(IMG_H - 1);

    // Position counters and registered outputs
    logic [c_col_w-1:0]      r_col_q,   w_col_d;
    logic [c_row_w-1:0]      r_row_q,   w_row_d;
    logic                    r_valid_q, w_valid_d;
    logic                    r_last_q,  w_last_d;
    logic [9*DATA_W-1:0]     r_win_q,   w_win_d;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 at each column.
    // Their contents are never reset; row/col gating keeps stale data out
    // of every valid window.
    logic [DATA_W-1:0]       r_lb0_mem [IMG_W];
    logic [DATA_W-1:0]       r_lb1_mem [IMG_W];

    logic [DATA_W-1:0]       w_lb0_rd;
    logic [DATA_W-1:0]       w_lb1_rd;
    logic [3*DATA_W-1:0]     w_col_in;

    assign w_lb0_rd = r_lb0_mem[r_col_q];
    assign w_lb1_rd = r_lb1_mem[r_col_q];
    // New right-hand column, top (row r-2) in the low slot
    assign w_col_in = {win_if.In_Pixel, w_lb0_rd, w_lb1_rd};

    // Next-state: counter advance, window shift and validity flags on accept
    always_comb begin
        w_col_d   = r_col_q;
        w_row_d   = r_row_q;
        w_valid_d = 1'b0;
        w_last_d  = 1'b0;
        w_win_d   = r_win_q;
        if (win_if.In_Valid) begin
            if (r_col_q == c_col_max) begin
                w_col_d = '0;
                w_row_d = (r_row_q == c_row_max) ? '0 : r_row_q + c_row_w'(1);
            end else begin
                w_col_d = r_col_q + c_col_w'(1);
            end
            w_valid_d = (r_row_q >= c_row_w'(2)) && (r_col_q >= c_col_w'(2));
            w_last_d  = (r_row_q == c_row_max) && (r_col_q == c_col_max);
            // Shift each window row one slot left and insert the new column
            for (int i = 0; i < 3; i++) begin
                w_win_d[(3*i)*DATA_W   +: DATA_W] = r_win_q[(3*i+1)*DATA_W +: DATA_W];
                w_win_d[(3*i+1)*DATA_W +: DATA_W] = r_win_q[(3*i+2)*DATA_W +: DATA_W];
                w_win_d[(3*i+2)*DATA_W +: DATA_W] = w_col_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // State registers; reset wins over a same-cycle accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_q   <= '0;
            r_row_q   <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_win_q   <= '0;
        end else begin
            r_col_q   <= w_col_d;
            r_row_q   <= w_row_d;
            r_valid_q <= w_valid_d;
            r_last_q  <= w_last_d;
            r_win_q   <= w_win_d;
        end
    end

    // Line buffer update: current pixel into lb0, displaced lb0 value into lb1
    always_ff @(posedge clk) begin
        if (win_if.In_Valid && !rst) begin
            r_lb0_mem[r_col_q] <= win_if.In_Pixel;
            r_lb1_mem[r_col_q] <= w_lb0_rd;
        end
    end

    assign win_if.Out_Valid  = r_valid_q;
    assign win_if.Out_Last   = r_last_q;
    assign win_if.Out_Window = r_win_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_window_3x3
// Description : Self-checking bench for line_window_3x3 (5x4 image, 8-bit).
//               Stimulus pushes expected windows into a scoreboard queue. A
//               monitor pops and compares on every Out_Valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_3x3;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_window_3x3_if #(.DATA_W(DW)) tif ();

    line_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .win_if (tif.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: the image as a plain 2-D array, plus position
    logic [DW-1:0]   img [H][W];
    int              mr = 0;
    int              mc = 0;
    exp_t            exp_q [$];
    logic [9*DW-1:0] got_win [$];
    logic            got_last [$];

    int n_chk  = 0;
    int n_fail = 0;

    logic            mon_en = 1'b0;
    logic            acc_s  = 1'b0;
    logic            rst_s  = 1'b0;
    logic [9*DW-1:0] prev_win;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model of one accepted pixel: store it, emit a window if r>=2 and c>=2
    task automatic model_accept(input logic [DW-1:0] px);
        exp_t e;
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(3*i+j)*DW +: DW] = img[mr-2+i][mc-2+j];
            e.last = (mr == H-1) && (mc == W-1);
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endtask

    task automatic send(input logic v, input logic [DW-1:0] px);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        tif.In_Valid = v;
        tif.In_Pixel = px;
        if (v) model_accept(px);
    endtask

    task automatic do_reset(input logic v, input logic [DW-1:0] px);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        tif.In_Valid = v;
        tif.In_Pixel = px;
        mr = 0;
        mc = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, DW'($urandom));
    endtask

    // Frame with pixel = base + 10*r + c, optional idle cycle after each pixel
    task automatic send_frame(input int base, input logic gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(1'b1, DW'(base + 10*r + c));
                if (gap) send(1'b0, DW'($urandom));
            end
    endtask

    // Record what the DUT sampled at each edge
    always @(posedge clk) begin
        acc_s <= tif.In_Valid && !rst;
        rst_s <= rst;
    end

    // Monitor: idle/reset invariants and scoreboard comparison
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_s) begin
                chk("rst_out_valid",  {127'd0, tif.Out_Valid}, 128'd0);
                chk("rst_out_last",   {127'd0, tif.Out_Last},  128'd0);
                chk("rst_out_window", {56'd0, tif.Out_Window}, 128'd0);
            end else if (!acc_s) begin
                chk("idle_valid",  {127'd0, tif.Out_Valid}, 128'd0);
                chk("idle_window_hold", {56'd0, tif.Out_Window}, {56'd0, prev_win});
            end
            if (tif.Out_Valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", {56'd0, tif.Out_Window}, 128'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("window", {56'd0, tif.Out_Window}, {56'd0, e.win});
                    chk("last",   {127'd0, tif.Out_Last},  {127'd0, e.last});
                    got_win.push_back(tif.Out_Window);
                    got_last.push_back(tif.Out_Last);
                end
            end
            prev_win = tif.Out_Window;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        tif.In_Valid = 1'b0;
        tif.In_Pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en   = 1'b1;
        prev_win = '0;

        // Reset state
        @(negedge clk);
        chk("reset_valid",  {127'd0, tif.Out_Valid}, 128'd0);
        chk("reset_last",   {127'd0, tif.Out_Last},  128'd0);
        chk("reset_window", {56'd0, tif.Out_Window}, 128'd0);

        // Continuous frame
        b = got_win.size();
        send_frame(0, 1'b0);
        idle(3);
        chk("frame1_count", 128'(got_win.size() - b), 128'd6);
        if (got_win.size() >= b + 6) begin
            chk("frame1_first", {56'd0, got_win[b]},
                {56'd0, 72'h16_15_14_0C_0B_0A_02_01_00});
            chk("frame1_lastwin", {56'd0, got_win[b+5]},
                {56'd0, 72'h22_21_20_18_17_16_0E_0D_0C});
            chk("frame1_lastflag", {127'd0, got_last[b+5]}, 128'd1);
        end

        // Same frame with gaps
        b = got_win.size();
        send_frame(0, 1'b1);
        idle(2);
        chk("gapped_count", 128'(got_win.size() - b), 128'd6);
        if (got_win.size() >= b + 1)
            chk("gapped_first", {56'd0, got_win[b]},
                {56'd0, 72'h16_15_14_0C_0B_0A_02_01_00});

        // Two back-to-back frames
        b = got_win.size();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(2);
        chk("b2b_count", 128'(got_win.size() - b), 128'd12);
        if (got_win.size() >= b + 7)
            chk("b2b_frame2_first", {56'd0, got_win[b+6]},
                {56'd0, 72'h7A_79_78_70_6F_6E_66_65_64});

        // Reset after 13 pixels, then a full frame
        for (int k = 0; k < 13; k++) send(1'b1, DW'(10*(k/W) + k%W));
        do_reset(1'b0, '0);
        b = got_win.size() + exp_q.size();
        send_frame(0, 1'b0);
        idle(2);
        chk("post_reset_count", 128'(got_win.size() - b), 128'd6);

        // Reset together with In_Valid: pixel dropped, outputs zero
        send(1'b1, 8'h55);
        send(1'b1, 8'h56);
        do_reset(1'b1, 8'hAA);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid_window", {56'd0, tif.Out_Window}, 128'd0);

        // Reset hold then 10 idle cycles
        do_reset(1'b0, '0);
        do_reset(1'b0, '0);
        idle(10);
        @(negedge clk);
        chk("hold_idle_window", {56'd0, tif.Out_Window}, 128'd0);
        chk("hold_idle_valid",  {127'd0, tif.Out_Valid}, 128'd0);

        // Randomized traffic: random pixels, random gaps, occasional reset
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset($urandom_range(0, 1) == 1, DW'($urandom));
            else if ($urandom_range(0, 3) == 0)
                send(1'b0, DW'($urandom));
            else
                send(1'b1, DW'($urandom));
        end
        idle(3);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
